gf251_mul_arbiter: RTL and testbench

- Round-robin arbiter that shares one pipelined gf251_mul instance among NREQ requesters: at most one operand pair is issued into the multiplier per cycle.
- A tag pipeline records which requester owns each in-flight operation, and each product is returned to its owner.
- Sits between the GF(251) vector/matrix engines and the single field multiplier; it replaces ad-hoc start muxing in each engine.

---
 rtl/gf251_pkg.sv | 15 +
 rtl/gf251_mul.sv | 53 +++++
 rtl/rr_arbiter.sv | 25 ++
 rtl/gf251_mul_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_gf251_mul_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf251_pkg.sv
// Shared GF(251) types and helpers for the field-multiplier datapath and its schedulers.
package gf251_pkg;

    localparam int GF251_P      = 251;
    localparam int NREQ_DEFAULT = 4;

    typedef logic [7:0]                       gf_elem_t;
    typedef logic [$clog2(NREQ_DEFAULT)-1:0]  req_id_t;

    // Operands are < 251, so the raw product always fits in 16 bits.
    function automatic gf_elem_t gf251_reduce(input logic [15:0] prod);
        return gf_elem_t'(prod % 16'(GF251_P));
    endfunction

endpackage

// File: rtl/gf251_mul.sv
// Two-stage GF(251) multiplier: raw product, then modular reduction.
// done/out are valid two cycles after start is sampled high.
module gf251_mul
    import gf251_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     start,
    input  gf_elem_t in_1,
    input  gf_elem_t in_2,
    output logic     done,
    output gf_elem_t out
);

    logic [15:0] prod_r;
    logic        prod_v_r;
    gf_elem_t    out_r;
    logic        done_r;

    // Stage 1: capture the raw 16-bit product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r   <= 16'd0;
            prod_v_r <= 1'b0;
        end else begin
            prod_v_r <= start;
            if (start) begin
                prod_r <= {8'd0, in_1} * {8'd0, in_2};
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    // Stage 2: reduce modulo 251 and flag completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r  <= 8'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= prod_v_r;
            if (prod_v_r) begin
                out_r <= gf251_reduce(prod_r);
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign done = done_r;
    assign out  = out_r;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant
);

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx        = IDW'((int'(ptr) + i) % NREQ);
            grant[idx] = req[idx] & ~found;
            found      = found | req[idx];
        end
    end

endmodule

// File: rtl/gf251_mul_arbiter.sv
// Shares one pipelined gf251_mul among NREQ requesters with round-robin issue
// and a tag pipeline that routes each product back to its owner.
module gf251_mul_arbiter
    import gf251_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int MUL_LAT = 2,
    localparam int IDW     = $clog2(NREQ),
    localparam int CNTW    = $clog2(MUL_LAT + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_in_1,
    input  logic [8*NREQ-1:0] req_in_2,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   res_valid,
    output gf_elem_t          res_out,
    output logic [IDW-1:0]    res_id,
    output logic [CNTW-1:0]   inflight,
    output logic              err
);

    localparam int INF_CAP = ((MUL_LAT + 1) > ((1 << CNTW) - 1)) ? ((1 << CNTW) - 1) : (MUL_LAT + 1);

    logic [IDW-1:0]  ptr_r;
    logic [NREQ-1:0] grant_raw_s;
    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  gnt_id_s;
    logic            issue_s;
    gf_elem_t        mul_in_1_s;
    gf_elem_t        mul_in_2_s;
    logic            mul_start_s;
    logic            mul_done_s;
    gf_elem_t        mul_out_s;
    logic            done_eff_s;

    logic [MUL_LAT-1:0] tag_v_r;
    logic [IDW-1:0]     tag_id_r [MUL_LAT];
    logic [CNTW-1:0]    mask_r;

    logic [NREQ-1:0] res_valid_r;
    gf_elem_t        res_out_r;
    logic [IDW-1:0]  res_id_r;
    logic            retire_r;
    logic [CNTW-1:0] inflight_r;
    logic [CNTW-1:0] inflight_nxt_s;
    logic            err_r;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_raw_s)
    );

    // Grant is suppressed while reset is held so no handshake can complete.
    always_comb begin
        grant_s = grant_raw_s & {NREQ{i_rst_n}};
    end

    // One-hot grant to ID and operand mux; ungranted cycles drive zero operands.
    always_comb begin
        gnt_id_s   = '0;
        mul_in_1_s = 8'd0;
        mul_in_2_s = 8'd0;
        for (int k = 0; k < NREQ; k++) begin
            gnt_id_s   = gnt_id_s   | (IDW'(k) & {IDW{grant_s[k]}});
            mul_in_1_s = mul_in_1_s | (req_in_1[8*k +: 8] & {8{grant_s[k]}});
            mul_in_2_s = mul_in_2_s | (req_in_2[8*k +: 8] & {8{grant_s[k]}});
        end
        issue_s     = |grant_s;
        mul_start_s = issue_s;
    end

    gf251_mul u_mul (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .start (mul_start_s),
        .in_1  (mul_in_1_s),
        .in_2  (mul_in_2_s),
        .done  (mul_done_s),
        .out   (mul_out_s)
    );

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r <= '0;
        end else if (issue_s) begin
            ptr_r <= (gnt_id_s == IDW'(NREQ - 1)) ? '0 : gnt_id_s + IDW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Tag pipeline: last stage lines up with the multiplier's done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_v_r <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_id_r[i] <= '0;
            end
        end else begin
            tag_v_r[0]  <= issue_s;
            tag_id_r[0] <= gnt_id_s;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Ignore done for MUL_LAT cycles after reset so stale completions are not seen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_r <= CNTW'(MUL_LAT);
        end else if (mask_r != '0) begin
            mask_r <= mask_r - CNTW'(1);
        end else begin
            mask_r <= mask_r;
        end
    end

    assign done_eff_s = mul_done_s & (mask_r == '0);

    // Registered return path and sticky tag/done disagreement flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            res_valid_r <= '0;
            res_out_r   <= 8'd0;
            res_id_r    <= '0;
            retire_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            res_valid_r <= '0;
            if (tag_v_r[MUL_LAT-1] & done_eff_s) begin
                res_valid_r[tag_id_r[MUL_LAT-1]] <= 1'b1;
            end else begin
                res_valid_r <= '0;
            end
            res_out_r <= mul_out_s;
            res_id_r  <= tag_id_r[MUL_LAT-1];
            retire_r  <= tag_v_r[MUL_LAT-1];
            err_r     <= err_r | (done_eff_s != tag_v_r[MUL_LAT-1]);
        end
    end

    // Occupancy tracks issues against retiring tags; it saturates rather than wraps.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({issue_s, retire_r})
            2'b10: begin
                if (inflight_r == CNTW'(INF_CAP)) begin
                    inflight_nxt_s = inflight_r;
                end else begin
                    inflight_nxt_s = inflight_r + CNTW'(1);
                end
            end
            2'b01: begin
                if (inflight_r == '0) begin
                    inflight_nxt_s = inflight_r;
                end else begin
                    inflight_nxt_s = inflight_r - CNTW'(1);
                end
            end
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inflight_r <= '0;
        end else begin
            inflight_r <= inflight_nxt_s;
        end
    end

    assign req_ready = grant_s;
    assign res_valid = res_valid_r;
    assign res_out   = res_out_r;
    assign res_id    = res_id_r;
    assign inflight  = inflight_r;
    assign err       = err_r;

endmodule

// File: tb/tb_gf251_mul_arbiter.sv
// Randomised and directed bench for gf251_mul_arbiter against a queue-based reference model.
module tb_gf251_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;
    localparam int IDW     = 2;
    localparam int CW      = 2;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_in_1 = '0;
    logic [8*NREQ-1:0] req_in_2 = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   res_valid;
    logic [7:0]        res_out;
    logic [IDW-1:0]    res_id;
    logic [CW-1:0]     inflight;
    logic              err;

    gf251_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .req_valid (req_valid),
        .req_in_1  (req_in_1),
        .req_in_2  (req_in_2),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_out   (res_out),
        .res_id    (res_id),
        .inflight  (inflight),
        .err       (err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int due; int id; int prod; } pend_t;
    typedef struct { int cyc; int id; int val; } obs_t;

    pend_t     pend_q[$];
    obs_t      obs_q[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        m_ptr   = 0;
    int        cyc     = 0;
    int        last_gnt = -1;
    bit        m_err   = 1'b0;
    bit        v[NREQ];
    logic [7:0] op_a[NREQ];
    logic [7:0] op_b[NREQ];

    task automatic apply_inputs();
        for (int k = 0; k < NREQ; k++) begin
            req_valid[k]        = v[k];
            req_in_1[8*k +: 8]  = op_a[k];
            req_in_2[8*k +: 8]  = op_b[k];
        end
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NREQ; k++) begin
            v[k] = 1'b0;
        end
    endtask

    // One clock of stimulus plus scoreboard comparison.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rv;
        @(negedge i_clk);
        apply_inputs();
        #1;
        g = -1;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (g < 0 && v[k]) g = k;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        n_tests++;
        if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
        end
        n_tests++;
        if (dut.mul_start_s !== (g >= 0)) begin
            n_fail++;
            $display("FAIL start cyc=%0d got=%b exp=%b", cyc, dut.mul_start_s, (g >= 0));
        end
        n_tests++;
        if (inflight !== CW'(pend_q.size())) begin
            n_fail++;
            $display("FAIL inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, pend_q.size());
        end
        exp_rv = '0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            exp_rv[pend_q[0].id] = 1'b1;
            n_tests++;
            if (res_out !== 8'(pend_q[0].prod) || res_id !== IDW'(pend_q[0].id)) begin
                n_fail++;
                $display("FAIL res_data cyc=%0d got=%0d/id%0d exp=%0d/id%0d",
                         cyc, res_out, res_id, pend_q[0].prod, pend_q[0].id);
            end
            void'(pend_q.pop_front());
        end
        n_tests++;
        if (res_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL res_valid cyc=%0d got=%b exp=%b", cyc, res_valid, exp_rv);
        end
        n_tests++;
        if (err !== m_err) begin
            n_fail++;
            $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, m_err);
        end
        if (res_valid != '0) obs_q.push_back('{cyc, int'(res_id), int'(res_out)});
        last_gnt = g;
        if (g >= 0) begin
            pend_q.push_back('{cyc + MUL_LAT + 1, g, (int'(op_a[g]) * int'(op_b[g])) % 251});
            m_ptr = (g + 1) % NREQ;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset held for ncyc cycles with every requester valid; outputs must stay at reset values.
    task automatic drive_reset(input int ncyc);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            v[k]    = 1'b1;
            op_a[k] = 8'($urandom_range(0, 250));
            op_b[k] = 8'($urandom_range(0, 250));
        end
        apply_inputs();
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge i_clk);
            #1;
            n_tests++;
            if (req_ready !== '0 || res_valid !== '0) begin
                n_fail++;
                $display("FAIL rst_handshake ready=%b res_valid=%b exp=0/0", req_ready, res_valid);
            end
            n_tests++;
            if (res_out !== 8'd0 || res_id !== '0 || inflight !== '0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_outputs out=%0d id=%0d inflight=%0d err=%b exp all 0",
                         res_out, res_id, inflight, err);
            end
        end
        @(negedge i_clk);
        clear_reqs();
        apply_inputs();
        i_rst_n = 1'b1;
        pend_q.delete();
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    task automatic test_reset();
        drive_reset(3);
        idle(MUL_LAT + 2);
    endtask

    task automatic test_round_robin();
        obs_q.delete();
        for (int k = 0; k < NREQ; k++) begin
            v[k] = 1'b1; op_a[k] = 8'(k + 1); op_b[k] = 8'd2;
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if (last_gnt != i % NREQ) begin
                n_fail++;
                $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, last_gnt, i % NREQ);
            end
        end
        idle(MUL_LAT + 3);
        n_tests++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL rr_count got=%0d exp=8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (obs_q[i].id != i % NREQ || obs_q[i].val != 2 * (i % NREQ + 1)) begin
                    n_fail++;
                    $display("FAIL rr_result i=%0d got=%0d/id%0d exp=%0d/id%0d",
                             i, obs_q[i].val, obs_q[i].id, 2 * (i % NREQ + 1), i % NREQ);
                end
            end
        end
    endtask

    task automatic test_single();
        int a_vec[3];
        int b_vec[3];
        int p_vec[3];
        int first;
        a_vec = '{1, 34, 62};
        b_vec = '{20, 31, 85};
        p_vec = '{20, 50, 250};
        obs_q.delete();
        clear_reqs();
        first = cyc;
        for (int i = 0; i < 3; i++) begin
            v[0] = 1'b1; op_a[0] = 8'(a_vec[i]); op_b[0] = 8'(b_vec[i]);
            step();
        end
        idle(MUL_LAT + 3);
        n_tests++;
        if (obs_q.size() != 3) begin
            n_fail++;
            $display("FAIL single_count got=%0d exp=3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (obs_q[i].val != p_vec[i] || obs_q[i].id != 0 || obs_q[i].cyc != first + MUL_LAT + 1 + i) begin
                    n_fail++;
                    $display("FAIL single_result i=%0d got=%0d/id%0d@%0d exp=%0d/id0@%0d",
                             i, obs_q[i].val, obs_q[i].id, obs_q[i].cyc, p_vec[i], first + MUL_LAT + 1 + i);
                end
            end
        end
    endtask

    task automatic test_sparse();
        int exp_seq[4];
        exp_seq = '{3, 1, 3, 1};
        clear_reqs();
        v[1] = 1'b1; op_a[1] = 8'd5; op_b[1] = 8'd7;
        step();
        for (int i = 0; i < 4; i++) begin
            v[1] = 1'b1; v[3] = 1'b1;
            if (last_gnt == 1) begin
                op_a[1] = 8'($urandom_range(0, 250)); op_b[1] = 8'($urandom_range(0, 250));
            end
            if (last_gnt == 3) begin
                op_a[3] = 8'($urandom_range(0, 250)); op_b[3] = 8'($urandom_range(0, 250));
            end
            step();
            n_tests++;
            if (last_gnt != exp_seq[i] || (req_ready & 4'b0101) !== 4'b0000) begin
                n_fail++;
                $display("FAIL sparse_grant i=%0d got=%0d ready=%b exp=%0d", i, last_gnt, req_ready, exp_seq[i]);
            end
        end
        idle(MUL_LAT + 4);
    endtask

    task automatic test_boundary();
        int a_vec[3];
        int b_vec[3];
        int p_vec[3];
        int max_inf;
        a_vec = '{250, 0, 250};
        b_vec = '{250, 137, 2};
        p_vec = '{1, 0, 249};
        obs_q.delete();
        clear_reqs();
        max_inf = 0;
        for (int i = 0; i < 6; i++) begin
            v[2] = 1'b1;
            op_a[2] = (i < 3) ? 8'(a_vec[i]) : 8'($urandom_range(0, 250));
            op_b[2] = (i < 3) ? 8'(b_vec[i]) : 8'($urandom_range(0, 250));
            step();
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
        end
        n_tests++;
        if (max_inf != MUL_LAT + 1) begin
            n_fail++;
            $display("FAIL inflight_peak got=%0d exp=%0d", max_inf, MUL_LAT + 1);
        end
        idle(MUL_LAT + 3);
        n_tests++;
        if (inflight !== '0) begin
            n_fail++;
            $display("FAIL inflight_drain got=%0d exp=0", inflight);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (obs_q.size() <= i || obs_q[i].val != p_vec[i]) begin
                n_fail++;
                $display("FAIL boundary i=%0d got=%0d exp=%0d", i, (obs_q.size() > i) ? obs_q[i].val : -1, p_vec[i]);
            end
        end
    endtask

    task automatic test_random();
        int wait_c[NREQ];
        int worst;
        clear_reqs();
        for (int k = 0; k < NREQ; k++) wait_c[k] = 0;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (last_gnt == k || !v[k]) begin
                    v[k]    = ($urandom_range(0, 2) != 0);
                    op_a[k] = 8'($urandom_range(0, 250));
                    op_b[k] = 8'($urandom_range(0, 250));
                end
            end
            step();
            worst = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (v[k] && last_gnt != k) wait_c[k]++;
                else wait_c[k] = 0;
                if (wait_c[k] > worst) worst = wait_c[k];
            end
            n_tests++;
            if (worst >= NREQ) begin
                n_fail++;
                $display("FAIL starvation cyc=%0d wait=%0d limit=%0d", cyc, worst, NREQ - 1);
            end
        end
        idle(MUL_LAT + 3);
    endtask

    task automatic test_reset_midflight();
        clear_reqs();
        obs_q.delete();
        for (int i = 0; i < 2; i++) begin
            v[0] = 1'b1; op_a[0] = 8'(9 + i); op_b[0] = 8'(11 + i);
            step();
        end
        drive_reset(3);
        idle(MUL_LAT + 3);
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL flushed_result got=%0d results exp=0", obs_q.size());
        end
        v[2] = 1'b1; op_a[2] = 8'd17; op_b[2] = 8'd33;
        step();
        idle(MUL_LAT + 3);
        n_tests++;
        if (obs_q.size() != 1 || obs_q[0].val != 59 || obs_q[0].id != 2) begin
            n_fail++;
            $display("FAIL post_reset_issue count=%0d exp 1 result 59 from id 2", obs_q.size());
        end
    endtask

    task automatic test_error();
        idle(2);
        force dut.mul_done_s = 1'b1;
        @(posedge i_clk);
        #1;
        release dut.mul_done_s;
        m_err = 1'b1;
        idle(4);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky got=%b exp=1", err);
        end
        drive_reset(2);
        idle(2);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear got=%b exp=0", err);
        end
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            v[k] = 1'b0; op_a[k] = 8'd0; op_b[k] = 8'd0;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_sparse();
        test_boundary();
        test_random();
        test_reset_midflight();
        test_error();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout after 100000 time units");
        $fatal(1);
    end

endmodule
